// File: rtl/led_anim_sched.sv
// Command scheduler between the IR remote decoder and the LED animation datapath.
// It applies each decoded button press once, then ignores the remote for a holdoff
// window and until the button is released. It holds the speed level and the
// selected animation, and it generates the frame-step pulse and the frame index.
module led_anim_sched #(
    parameter int unsigned BASE_DIV = 1000000,
    parameter int unsigned HOLDOFF  = 2000000,
    parameter int unsigned FRAMES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
    output logic [2:0] speed,
    output logic [1:0] anim_sel,
    output logic [2:0] frame,
    output logic       step,
    output logic       cmd_ack
);

    localparam int unsigned PW = $clog2(BASE_DIV);
    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(BASE_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF - 1);
    localparam logic [2:0]    FRAME_LAST = 3'(FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [2:0]    cmd_lat_q, cmd_lat_d;
    logic [HW-1:0] hold_q,    hold_d;
    logic [PW-1:0] pre_q,     pre_d;
    logic [2:0]    div_q,     div_d;
    logic [2:0]    speed_q,   speed_d;
    logic [1:0]    anim_q,    anim_d;
    logic [2:0]    frame_q,   frame_d;
    logic          step_q,    step_d;
    logic          ack_q,     ack_d;
    logic          base_tick;
    logic          step_due;

    // Next-state logic: timebase, step divider, frame counter and command FSM.
    always_comb begin
        state_d   = state_q;
        cmd_lat_d = cmd_lat_q;
        hold_d    = hold_q;
        speed_d   = speed_q;
        anim_d    = anim_q;
        ack_d     = 1'b0;

        // Prescaler wraps after its last count; that count is the base tick.
        base_tick = (pre_q == PRE_LAST);
        // limit-1 = 7-speed; ">=" lets a speed-up below div_q step on the next tick.
        step_due  = base_tick && (div_q >= (3'd7 - speed_q));

        if (base_tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end

        if (step_due) begin
            div_d = 3'd0;
        end else if (base_tick) begin
            div_d = div_q + 3'd1;
        end else begin
            div_d = div_q;
        end

        step_d = step_due;
        if (step_due) begin
            frame_d = (frame_q == FRAME_LAST) ? 3'd0 : (frame_q + 3'd1);
        end else begin
            frame_d = frame_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) begin
                    cmd_lat_d = cmd;
                    state_d   = ST_APPLY;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_APPLY: begin
                ack_d   = 1'b1;
                hold_d  = '0;
                state_d = ST_HOLD;
                case (cmd_lat_q)
                    3'd1: speed_d = (speed_q == 3'd0) ? 3'd0 : (speed_q - 3'd1);
                    3'd2: speed_d = (speed_q == 3'd7) ? 3'd7 : (speed_q + 3'd1);
                    3'd3, 3'd4, 3'd5: begin
                        // Animation select restarts the sequence and overrides a due step.
                        anim_d  = 2'(cmd_lat_q - 3'd3);
                        frame_d = 3'd0;
                        pre_d   = '0;
                        div_d   = 3'd0;
                        step_d  = 1'b0;
                    end
                    default: speed_d = speed_q;
                endcase
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    // Leave only once the button is released, so a held key never repeats.
                    if (cmd == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_lat_q <= 3'd0;
            hold_q    <= '0;
            pre_q     <= '0;
            div_q     <= 3'd0;
            speed_q   <= 3'd3;
            anim_q    <= 2'd0;
            frame_q   <= 3'd0;
            step_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_lat_q <= cmd_lat_d;
            hold_q    <= hold_d;
            pre_q     <= pre_d;
            div_q     <= div_d;
            speed_q   <= speed_d;
            anim_q    <= anim_d;
            frame_q   <= frame_d;
            step_q    <= step_d;
            ack_q     <= ack_d;
        end
    end

    assign speed    = speed_q;
    assign anim_sel = anim_q;
    assign frame    = frame_q;
    assign step     = step_q;
    assign cmd_ack  = ack_q;

endmodule

// File: tb/tb_led_anim_sched.sv
// Bench for led_anim_sched: a behavioural model checked every cycle, directed
// scenarios with hand-computed expectations, then randomized command traffic.
module tb_led_anim_sched;

    localparam int BASE_DIV = 4;
    localparam int HOLDOFF  = 10;
    localparam int FRAMES   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cmd = 3'd0;
    logic [2:0] speed;
    logic [1:0] anim_sel;
    logic [2:0] frame;
    logic       step;
    logic       cmd_ack;

    led_anim_sched #(.BASE_DIV(BASE_DIV), .HOLDOFF(HOLDOFF), .FRAMES(FRAMES)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .speed(speed), .anim_sel(anim_sel),
        .frame(frame), .step(step), .cmd_ack(cmd_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: time since last restart, divider progress, pending press, lockout age.
    int m_speed, m_anim, m_frame, m_step, m_ack;
    int m_t, m_div, m_pend, m_pcmd, m_lock;
    int m_tick, m_fire;

    always @(posedge clk) begin
        if (rst) begin
            m_speed = 3; m_anim = 0; m_frame = 0; m_step = 0; m_ack = 0;
            m_t = 0; m_div = 0; m_pend = 0; m_pcmd = 0; m_lock = -1;
        end else begin
            m_tick = ((m_t % BASE_DIV) == BASE_DIV - 1) ? 1 : 0;
            m_fire = 0;
            if (m_tick == 1) begin
                if (m_div + 1 >= 8 - m_speed) begin
                    m_fire = 1;
                    m_div  = 0;
                end else begin
                    m_div++;
                end
            end
            m_t++;
            m_step = 0;
            m_ack  = 0;
            if (m_pend == 1) begin
                m_ack = 1;
                if (m_pcmd == 1) m_speed = (m_speed == 0) ? 0 : m_speed - 1;
                else if (m_pcmd == 2) m_speed = (m_speed == 7) ? 7 : m_speed + 1;
                else begin
                    m_anim = m_pcmd - 3; m_frame = 0; m_t = 0; m_div = 0; m_fire = 0;
                end
            end
            if (m_fire == 1) begin
                m_step  = 1;
                m_frame = (m_frame + 1) % FRAMES;
            end
            if (m_pend == 1) begin
                m_pend = 0;
                m_lock = 0;
            end else if (m_lock >= 0) begin
                if (m_lock >= HOLDOFF - 1) begin
                    if (cmd == 3'd0) m_lock = -1;
                end else begin
                    m_lock++;
                end
            end else if (cmd >= 3'd1 && cmd <= 3'd5) begin
                m_pend = 1;
                m_pcmd = int'(cmd);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("speed",    int'(speed),    m_speed);
            check("anim_sel", int'(anim_sel), m_anim);
            check("frame",    int'(frame),    m_frame);
            check("step",     int'(step),     m_step);
            check("cmd_ack",  int'(cmd_ack),  m_ack);
        end
    end

    // Event monitor: step spacing, ack count, ack-to-first-step distance.
    int cyc = 0, last_step = -1000, prev_step = -1000, ack_cnt = 0, ack_cyc = 0;
    int ack2step = -1;
    bit wait_step = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (step) begin
            prev_step = last_step;
            last_step = cyc;
            if (wait_step) begin
                ack2step  = cyc - ack_cyc;
                wait_step = 1'b0;
            end
        end
        if (cmd_ack) begin
            ack_cnt++;
            ack_cyc   = cyc;
            wait_step = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] c);
        cmd = c;
        tick(2);
        cmd = 3'd0;
        tick(18);
    endtask

    task automatic wait_frame(input int val, input int budget);
        int n;
        n = 0;
        while (int'(frame) != val && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_frame_timeout", int'(frame), val);
    endtask

    int a0, n, len;

    initial begin
        // Reset and idle.
        tick(3);
        chk_en = 1'b1;
        check("rst_speed", int'(speed), 3);
        check("rst_anim",  int'(anim_sel), 0);
        check("rst_frame", int'(frame), 0);
        check("rst_step",  int'(step), 0);
        rst = 1'b0;
        tick(128);
        check("idle_speed",  int'(speed), 3);
        check("idle_frame",  int'(frame), 6);
        check("idle_period", last_step - prev_step, 20);

        // Speed up once; second press inside the lockout is ignored.
        a0 = ack_cnt;
        cmd = 3'd2; tick(2); cmd = 3'd0; tick(3);
        cmd = 3'd2; tick(2); cmd = 3'd0; tick(40);
        check("up_ack_once", ack_cnt - a0, 1);
        check("up_speed",    int'(speed), 4);
        check("up_period",   last_step - prev_step, 16);

        // Saturate up, then down.
        for (int i = 0; i < 5; i++) press(3'd2);
        tick(20);
        check("sat_hi_speed",  int'(speed), 7);
        check("sat_hi_period", last_step - prev_step, 4);
        for (int i = 0; i < 9; i++) press(3'd1);
        tick(80);
        check("sat_lo_speed",  int'(speed), 0);
        check("sat_lo_period", last_step - prev_step, 32);

        // Back to speed 3; animation select at frame 7 restarts the sequence.
        for (int i = 0; i < 3; i++) press(3'd2);
        wait_frame(7, 200);
        cmd = 3'd4; tick(2);
        check("sel_anim",  int'(anim_sel), 1);
        check("sel_frame", int'(frame), 0);
        cmd = 3'd0; tick(28);
        check("sel_first_step", ack2step, 20);

        // Natural wrap from frame 7.
        wait_frame(7, 200);
        n = 0;
        while (frame == 3'd7 && n < 40) begin tick(1); n++; end
        check("wrap_frame", int'(frame), 0);

        // Held button gives one ack; framing codes are ignored.
        a0 = ack_cnt;
        cmd = 3'd5; tick(40); cmd = 3'd0; tick(15);
        check("held_ack_once", ack_cnt - a0, 1);
        check("held_anim", int'(anim_sel), 2);
        a0 = ack_cnt;
        cmd = 3'd6; tick(5); cmd = 3'd7; tick(5); cmd = 3'd0; tick(5);
        check("framing_no_ack", ack_cnt - a0, 0);
        check("framing_anim",   int'(anim_sel), 2);
        check("framing_speed",  int'(speed), 3);

        // Reset mid-HOLD at speed 6, frame 5.
        for (int i = 0; i < 4; i++) press(3'd2);
        cmd = 3'd1;
        tick(4);
        check("pre_rst_speed", int'(speed), 6);
        wait_frame(5, 200);
        rst = 1'b1; cmd = 3'd0;
        tick(1);
        check("midrst_speed", int'(speed), 3);
        check("midrst_anim",  int'(anim_sel), 0);
        check("midrst_frame", int'(frame), 0);
        rst = 1'b0;
        a0 = ack_cnt;
        press(3'd3);
        check("post_rst_ack", ack_cnt - a0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1; tick(1); rst = 1'b0;
            end
            cmd = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) cmd = 3'd0;
            len = $urandom_range(1, 25);
            tick(len);
        end
        cmd = 3'd0;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
